// File: rtl/neuron_frame_sequencer_pkg.sv
// Shared definitions for the neuron datapath: Q4.12 word format and the
// frame sequencer state encoding.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;

  // Q4.12 constants.
  localparam logic [DATA_W-1:0] ONE  = 16'h1000;
  localparam logic [DATA_W-1:0] ZERO = 16'h0000;

  // Sequencer states.
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/neuron_frame_sequencer.sv
// Frame sequencer for one neuron instance. Serial Q4.12 words are gathered
// into a shadow buffer, committed to the neuron input bus as a whole frame,
// and after the neuron pipeline latency the activation is captured into a
// valid/ready output holding register.
module neuron_frame_sequencer #(
  parameter int INPUTS = 3,
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  output logic [INPUTS*DATA_W-1:0] vec_out,
  output logic                     vec_valid,
  input  logic [DATA_W-1:0]        nrn_in,
  output logic                     m_valid,
  output logic [DATA_W-1:0]        m_data,
  input  logic                     m_ready,
  output logic                     busy
);

  import nn_pkg::*;

  localparam int CNT_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int WAIT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [DATA_W-1:0]       shadow [INPUTS];
  logic [INPUTS*DATA_W-1:0] commit_vec;
  logic                    accept;
  logic                    last_word;
  logic                    wait_done;

  assign accept    = s_valid && s_ready && (state == ST_LOAD);
  assign last_word = (cnt == CNT_W'(INPUTS - 1));
  assign wait_done = (wait_cnt == WAIT_W'(LAT));

  // Frame as it will appear on the commit edge: stored lanes plus the
  // word arriving on that edge in the final lane.
  always_comb begin
    // NOTE: every bit gets a default before any conditional override, so no latch is inferred.
    commit_vec = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (i == INPUTS - 1) begin
        commit_vec[DATA_W*i +: DATA_W] = s_data;
      end else begin
        commit_vec[DATA_W*i +: DATA_W] = shadow[i];
      end
    end
  end

  // Control FSM: word counter, latency counter and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      wait_cnt  <= '0;
      s_ready   <= 1'b0;
      vec_valid <= 1'b0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      vec_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (last_word) begin
              vec_valid <= 1'b1;
              cnt       <= '0;
              wait_cnt  <= '0;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            m_valid <= 1'b1;
            state   <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        default: begin
          state   <= ST_LOAD;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: shadow lanes, committed frame and captured activation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow array is reset so a discarded partial frame can never leak into a later commit.
      for (int i = 0; i < INPUTS; i++) begin
        shadow[i] <= '0;
      end
      vec_out <= '0;
      m_data  <= DATA_W'(ZERO);
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        if (accept && (cnt == CNT_W'(i))) begin
          shadow[i] <= s_data;
        end
      end
      if (accept && last_word) begin
        vec_out <= commit_vec;
      end
      if ((state == ST_WAIT) && wait_done) begin
        m_data <= nrn_in;
      end
    end
  end

endmodule

// File: tb/tb_neuron_frame_sequencer.sv
// Directed bench for neuron_frame_sequencer with a scoreboard. Instance A
// uses INPUTS=3, LAT=1 with a registered neuron stub; instance B uses
// INPUTS=1, LAT=0 with a combinational stub. The stub activation is the
// wrapping sum of all lanes plus 16'h0800.
module tb_neuron_frame_sequencer;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic        s_valid, s_ready, vec_valid, m_valid, m_ready, busy;
  logic [15:0] s_data, nrn_in, m_data;
  logic [47:0] vec_out;
  // Instance B signals
  logic        s_valid_b, s_ready_b, vec_valid_b, m_valid_b, m_ready_b, busy_b;
  logic [15:0] s_data_b, nrn_in_b, m_data_b, vec_out_b;

  neuron_frame_sequencer #(.INPUTS(3), .DATA_W(16), .LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .vec_out(vec_out), .vec_valid(vec_valid), .nrn_in(nrn_in), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy));

  neuron_frame_sequencer #(.INPUTS(1), .DATA_W(16), .LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
    .vec_out(vec_out_b), .vec_valid(vec_valid_b), .nrn_in(nrn_in_b), .m_valid(m_valid_b),
    .m_data(m_data_b), .m_ready(m_ready_b), .busy(busy_b));

  // Neuron stubs: one register stage for A, none for B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nrn_in <= 16'h0000;
    else        nrn_in <= vec_out[15:0] + vec_out[31:16] + vec_out[47:32] + 16'h0800;
  end
  assign nrn_in_b = vec_out_b + 16'h0800;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vec_chg_a = 0;
  logic [47:0] prev_vec_a = '0;

  logic [47:0] exp_vec_a [$];
  logic [15:0] exp_res_a [$];
  logic [15:0] exp_vec_b [$];
  logic [15:0] exp_res_b [$];
  int          hs_cyc_a  [$];
  int          hs_cyc_b  [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always_ff @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vec_valid) begin
        if (exp_vec_a.size() == 0) check("vec_a_unexpected", 1, 0);
        else check("vec_a", vec_out, exp_vec_a.pop_front());
      end
      if (m_valid && m_ready) begin
        hs_cyc_a.push_back(cyc);
        if (exp_res_a.size() == 0) check("res_a_unexpected", 1, 0);
        else check("res_a", m_data, exp_res_a.pop_front());
      end
      if (vec_valid_b) begin
        if (exp_vec_b.size() == 0) check("vec_b_unexpected", 1, 0);
        else check("vec_b", vec_out_b, exp_vec_b.pop_front());
      end
      if (m_valid_b && m_ready_b) begin
        hs_cyc_b.push_back(cyc);
        if (exp_res_b.size() == 0) check("res_b_unexpected", 1, 0);
        else check("res_b", m_data_b, exp_res_b.pop_front());
      end
    end
    if (vec_out !== prev_vec_a) vec_chg_a++;
    prev_vec_a = vec_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one word on A and return just after the edge that accepts it.
  task automatic send_word_a(input logic [15:0] w);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) check("s_ready_a_timeout", 0, 1);
    tick();
  endtask

  task automatic send_frame_a(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    exp_vec_a.push_back({w2, w1, w0});
    exp_res_a.push_back(w0 + w1 + w2 + 16'h0800);
    send_word_a(w0);
    send_word_a(w1);
    send_word_a(w2);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_res_a.size() + exp_res_b.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    check(tag, exp_res_a.size() + exp_res_b.size(), 0);
  endtask

  initial begin
    int h0;
    int c0;
    rst_n = 1'b0;
    s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b0;
    s_valid_b = 1'b1; s_data_b = 16'h4321; m_ready_b = 1'b0;

    // Reset held 3 cycles with s_valid asserted.
    tick(3);
    check("rst_s_ready", s_ready, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_vec_out", vec_out, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready_b", s_ready_b, 0);
    check("rst_vec_out_b", vec_out_b, 0);
    s_valid = 1'b0; s_valid_b = 1'b0;
    rst_n = 1'b1;
    #1;
    check("s_ready_before_edge", s_ready, 0);
    tick();
    check("s_ready_after_edge", s_ready, 1);
    check("s_ready_b_after_edge", s_ready_b, 1);

    // Single frame, then backpressure.
    send_frame_a(ONE, ZERO, 16'hF000);
    s_valid = 1'b0;
    check("commit_vec_out", vec_out, 48'hF000_0000_1000);
    check("commit_vec_valid", vec_valid, 1);
    check("commit_s_ready", s_ready, 0);
    check("commit_busy", busy, 1);
    tick();
    check("wait_vec_valid", vec_valid, 0);
    check("wait_m_valid", m_valid, 0);
    check("wait_vec_out", vec_out, 48'hF000_0000_1000);
    tick();
    check("hold_m_valid", m_valid, 1);
    check("hold_m_data", m_data, 16'h0800);
    s_valid = 1'b1;
    s_data  = 16'hABCD;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", m_data, 16'h0800);
      check("bp_s_ready", s_ready, 0);
      check("bp_busy", busy, 1);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    check("release_m_valid", m_valid, 0);
    check("release_s_ready", s_ready, 1);
    check("release_busy", busy, 0);
    check("release_sb_empty", exp_res_a.size(), 0);

    // Throughput: two frames back to back.
    h0 = hs_cyc_a.size();
    c0 = vec_chg_a;
    send_frame_a(ONE, ONE, ZERO);
    send_frame_a(ZERO, ONE, ONE);
    s_valid = 1'b0;
    drain("tput_drain");
    check("tput_results", hs_cyc_a.size() - h0, 2);
    if (hs_cyc_a.size() >= h0 + 2) check("tput_period", hs_cyc_a[h0+1] - hs_cyc_a[h0], 6);
    check("tput_vec_updates", vec_chg_a - c0, 2);

    // Mid-frame reset discards the partial frame.
    send_word_a(16'h1111);
    send_word_a(16'h2222);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_vec_out", vec_out, 0);
    check("midrst_m_valid", m_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_s_ready", s_ready, 1);
    check("midrst_vec_hold", vec_out, 0);
    send_frame_a(16'h3333, 16'h4444, 16'h5555);
    s_valid = 1'b0;
    drain("midrst_drain");
    check("midrst_final_vec", vec_out, 48'h5555_4444_3333);
    check("midrst_idle_m_valid", m_valid, 0);

    // Instance B: INPUTS=1, LAT=0, continuous stream.
    m_ready_b = 1'b1;
    h0 = hs_cyc_b.size();
    s_valid_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] w;
      int n;
      w = (k == 0) ? 16'h1000 : (k == 1) ? 16'h7FFF : 16'h8001;
      exp_vec_b.push_back(w);
      exp_res_b.push_back(w + 16'h0800);
      s_data_b = w;
      n = 0;
      while (!s_ready_b && n < 50) begin
        tick();
        n++;
      end
      if (!s_ready_b) check("s_ready_b_timeout", 0, 1);
      tick();
      check("b_commit_vec", vec_out_b, w);
      check("b_commit_valid", vec_valid_b, 1);
      tick();
      check("b_m_valid", m_valid_b, 1);
      check("b_m_data", m_data_b, w + 16'h0800);
    end
    s_valid_b = 1'b0;
    drain("b_drain");
    check("b_results", hs_cyc_b.size() - h0, 3);
    if (hs_cyc_b.size() >= h0 + 3) begin
      check("b_period_1", hs_cyc_b[h0+1] - hs_cyc_b[h0], 3);
      check("b_period_2", hs_cyc_b[h0+2] - hs_cyc_b[h0+1], 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_frame_sequencer.md
Name: neuron_frame_sequencer

Overview:
- Streaming front/back end for one neuron instance.
- Collects INPUTS serial Q4.12 words over a valid/ready handshake into a shadow buffer.
- Commits the full frame as the packed neuron input vector, then waits out the sigmoid pipeline latency.
- Captures the neuron activation and presents it downstream on a valid/ready output holding register.

Parameters:
INPUTS, 3, number of neuron inputs (>=1); lane i occupies vec_out[DATA_W*i +: DATA_W]
DATA_W, 16, word width; signed Q4.12 (FRAC_W=12)
LAT, 1, registered latency in clk edges from neuron input change to valid activation (>=0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input word valid
s_data  in  DATA_W  input word, Q4.12
s_ready  out  1  block accepts s_data this cycle
vec_out  out  INPUTS*DATA_W  packed frame to neuron input bus
vec_valid  out  1  one-cycle pulse on the cycle after vec_out updates
nrn_in  in  DATA_W  activation returned from neuron output
m_valid  out  1  result valid
m_data  out  DATA_W  captured activation
m_ready  in  1  downstream accepts result
busy  out  1  high in WAIT or HOLD

Behaviour:
- Reset (rst_n low, async):
  - State=LOAD; word counter=0; wait counter=0.
  - Shadow buffer, vec_out, m_data all 0.
  - s_ready, vec_valid, m_valid, busy all 0.
  - s_ready is registered; it rises on the first clk edge after rst_n deasserts.
- States: LOAD, WAIT, HOLD. All outputs registered.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, s_data is written to shadow lane cnt and cnt increments.
  - Gaps on s_valid are allowed; counter holds.
  - On accept with cnt==INPUTS-1:
    - vec_out <= shadow with the final lane replaced by s_data (whole-bus commit, same edge).
    - vec_valid pulses high for the next cycle.
    - cnt <= 0; wait counter <= 0; s_ready <= 0; state <= WAIT.
- WAIT:
  - s_ready=0; vec_out stable.
  - Wait counter increments each edge.
  - At the (LAT+1)th edge after the commit edge: m_data <= nrn_in, m_valid <= 1, state <= HOLD.
- HOLD:
  - m_valid=1; m_data stable while m_ready=0; s_ready=0.
  - On m_valid&&m_ready: m_valid <= 0, s_ready <= 1, state <= LOAD.
- Latency and throughput:
  - Commit edge to m_valid high: LAT+1 edges.
  - Back-to-back frames with s_valid=1 and m_ready=1: one result per INPUTS+LAT+2 cycles.
- vec_out changes only on the commit edge; never partially updated; retained through LOAD of the next frame.
- s_valid while s_ready=0 is ignored; the word is not consumed.
- No arithmetic on data: words pass bit-exact.
- Reset mid-frame or mid-WAIT/HOLD: partial frame and pending result are discarded; no m_valid is emitted for them.
- m_ready asserted while m_valid=0: no effect.

Decomposition:
- Shared package nn_pkg holds:
  - DATA_W=16, FRAC_W=12.
  - Q4.12 constants ONE=16'h1000, ZERO=16'h0000.
  - Sequencer state encoding (LOAD=0, WAIT=1, HOLD=2).
- No sub-module: the FSM, counters, shadow buffer and output register are a single module.
- Bench instantiates it with the neuron, or with a stub that registers nrn_in with LAT edges of delay.

Test Plan:
- Reset: hold rst_n low 3 cycles with s_valid=1 -> all outputs 0; release -> s_ready=1 after first edge; nothing captured during reset.
- Single frame (INPUTS=3, LAT=1, stub nrn_in=16'h0800 after commit): send 16'h1000, 16'h0000, 16'hF000 back-to-back -> vec_out=48'hF000_0000_1000 at third accept edge; vec_valid high 1 cycle; m_valid high 2 edges after commit with m_data=16'h0800.
- Backpressure: m_ready=0 for 5 cycles, s_valid=1 continuously -> m_data/m_valid stable, s_ready=0, no word consumed; m_ready=1 -> m_valid drops next edge, s_ready=1.
- Throughput: two frames {16'h1000,16'h1000,16'h0000} and {16'h0000,16'h1000,16'h1000}, s_valid and m_ready tied 1 -> second result exactly 6 cycles after first; vec_out updates exactly twice.
- Mid-frame reset: accept 2 words, pulse rst_n low 1 cycle -> vec_out stays 0; next 3 words form a full new frame; no spurious m_valid.
- Variant INPUTS=1, LAT=0: each accepted word commits immediately; m_valid 1 edge after commit; period 3 cycles with m_ready=1.
